// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer controller: default widths and the
// controller state encoding. Optional macro SPI_BURST_EN adds the CS_HOLD state
// used to keep chip select low between the words of a burst.
package spi_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DIV_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_HOLD    = 3'd3
`ifdef SPI_BURST_EN
        ,
        ST_CS_HOLD = 3'd4
`endif
    } spi_state_t;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick generator. Counts 0..D-1 while enabled and emits a one-cycle
// tick on the wrap; divisor 0 behaves as 1. The counter sits at 0 when disabled
// so every enable starts a full half-period.
module spi_tick_gen #(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic [DIV_W-1:0] divisor,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] last;

    assign last = (divisor == '0) ? '0 : divisor - DIV_W'(1);
    assign tick = enable && (cnt == last);

    // Half-period counter: wraps on tick, cleared while disabled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (!enable || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 master transfer controller. One request moves one DATA_W word
// MSB first: mosi changes on sclk fall, miso is sampled on sclk rise.
// Handshake: a request is accepted in any cycle where tx_valid and tx_ready are
// both high; tx_data/spi_div are latched then, and rx_valid pulses for one cycle
// when the word completes with rx_data updated in that same cycle.
// Optional macro SPI_BURST_EN adds tx_last and keeps cs_n low between words.
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DIV_W  = DEF_DIV_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DIV_W-1:0]  spi_div,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
`ifdef SPI_BURST_EN
    input  logic              tx_last,
`endif
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    input  logic              miso
);

    localparam int EW = $clog2(2 * DATA_W + 1);

    spi_state_t        state;
    spi_state_t        state_next;
    logic              accept;
    logic              tick;
    logic              tick_en;
    logic [DIV_W-1:0]  div_q;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [EW-1:0]     edge_cnt;
`ifdef SPI_BURST_EN
    logic              last_q;
`endif

    // Ready in IDLE (and between burst words); forced low while reset is held.
`ifdef SPI_BURST_EN
    assign tx_ready = rstn && ((state == ST_IDLE) || (state == ST_CS_HOLD));
`else
    assign tx_ready = rstn && (state == ST_IDLE);
`endif
    assign accept  = tx_valid && tx_ready;
    assign busy    = (state != ST_IDLE);
    assign cs_n    = (state == ST_IDLE);
    assign mosi    = cs_n ? 1'b0 : tx_sr[DATA_W-1];
    assign tick_en = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);

    spi_tick_gen #(
        .DIV_W(DIV_W)
    ) u_tick (
        .clk     (clk),
        .rstn    (rstn),
        .enable  (tick_en),
        .divisor (div_q),
        .tick    (tick)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: every timed transition waits for a half-period tick.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_next = ST_SETUP;
            end
            ST_SETUP: begin
                if (tick) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                // The SETUP tick produced edge 1; the tick for edge 2*DATA_W ends SHIFT.
                if (tick && (edge_cnt == EW'(2 * DATA_W - 1))) state_next = ST_HOLD;
            end
            ST_HOLD: begin
`ifdef SPI_BURST_EN
                if (tick) state_next = last_q ? ST_IDLE : ST_CS_HOLD;
`else
                if (tick) state_next = ST_IDLE;
`endif
            end
`ifdef SPI_BURST_EN
            ST_CS_HOLD: begin
                if (accept) state_next = ST_SETUP;
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: latch request, toggle sclk on ticks, shift data, report completion.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q    <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            sclk     <= 1'b0;
            edge_cnt <= '0;
`ifdef SPI_BURST_EN
            last_q   <= 1'b1;
`endif
        end else begin
            rx_valid <= 1'b0;
            if (accept) begin
                div_q    <= spi_div;
                tx_sr    <= tx_data;
                sclk     <= 1'b0;
                edge_cnt <= '0;
`ifdef SPI_BURST_EN
                last_q   <= tx_last;
`endif
            end
            if (tick) begin
                case (state)
                    ST_SETUP: begin
                        sclk     <= 1'b1;
                        rx_sr    <= {rx_sr[DATA_W-2:0], miso};
                        edge_cnt <= EW'(1);
                    end
                    ST_SHIFT: begin
                        sclk     <= ~sclk;
                        edge_cnt <= edge_cnt + EW'(1);
                        if (!sclk) begin
                            rx_sr <= {rx_sr[DATA_W-2:0], miso};
                        end else begin
                            tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                        end
                    end
                    ST_HOLD: begin
                        rx_valid <= 1'b1;
                        rx_data  <= rx_sr;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
